// File: rtl/puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF evaluation engine:
// FSM states, LFSR polynomial, zero-seed substitute and select-width helper.
package puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COUNT,
      ST_CMP,
      ST_DONE
   } state_t;

   // x^8 + x^6 + x^5 + x^4 + 1 as a tap mask over lfsr[7:0]
   localparam logic [7:0] LFSR_TAPS     = 8'hB8;
   localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

   function automatic int sel_w(input int num_ro);
      return $clog2(num_ro);
   endfunction

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Rising-edge counter for one selected oscillator: preloadable previous-value
// register, saturating counter and sticky saturation flag.
module ro_edge_counter #(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             count_en,
   input  logic             level,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic prev;
   logic rise;

   assign rise = level & ~prev;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev  <= 1'b0;
         count <= '0;
         sat   <= 1'b0;
      end else if (load) begin
         // Preload with the current level so a mux change is not seen as an edge.
         prev  <= level;
         count <= '0;
         sat   <= 1'b0;
      end else if (count_en) begin
         prev <= level;
         if (rise && count != CNT_MAX)
            count <= count + 1'b1;
         if (rise && count >= CNT_MAX - 1'b1)
            sat <= 1'b1;
      end
   end

endmodule

// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF evaluation engine: LFSR-driven pair selection, windowed
// edge counting of two oscillators, per-bit compare with optional majority vote.
module ro_puf_eval
   import puf_pkg::*;
#(
   parameter int NUM_RO    = 16,
   parameter int CNT_W     = 12,
   parameter int WIN_W     = 16,
   parameter int RESP_BITS = 8,
   parameter int VOTES     = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [7:0]           challenge,
   input  logic [WIN_W-1:0]     window,
   input  logic                 vote_en,
   input  logic [NUM_RO-1:0]    ro_in,
   output logic                 busy,
   output logic                 done,
   output logic [RESP_BITS-1:0] response,
   output logic                 sat
);

   localparam int         SEL_W   = sel_w(NUM_RO);
   localparam int         IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
   localparam logic [2:0] VOTES_L = 3'(VOTES);

   state_t               state;
   logic [NUM_RO-1:0]    sync1, sync2;
   logic [7:0]           lfsr;
   logic [WIN_W-1:0]     win_q, win_cnt;
   logic                 vote_en_q;
   logic [IDX_W-1:0]     bit_idx;
   logic [2:0]           vote_idx, ones, ones_next, num_votes;
   logic [RESP_BITS-1:0] resp_sh, resp_next;
   logic                 sat_sh;
   logic [SEL_W-1:0]     sel_a, sel_b, a_now, b_now;
   logic                 level_a, level_b, sat_a, sat_b;
   logic [CNT_W-1:0]     cnt_a, cnt_b;
   logic                 resp_bit, last_vote, last_bit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= ro_in;
         sync2 <= sync1;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path infers a latch.
   always_comb begin
      a_now = lfsr[SEL_W-1:0];
      b_now = lfsr[2*SEL_W-1:SEL_W];
      if (b_now == a_now)
         b_now = a_now ^ SEL_W'(1);
      num_votes = vote_en_q ? VOTES_L : 3'd1;
      ones_next = ones + {2'b00, (cnt_a > cnt_b)};
      resp_bit  = ones_next > (num_votes >> 1);
      last_vote = (vote_idx == num_votes - 3'd1);
      last_bit  = (bit_idx == IDX_W'(RESP_BITS - 1));
      resp_next = resp_sh;
      resp_next[bit_idx] = resp_bit;
   end

   // During LOAD the new pair is not yet latched, so the preload reads it directly.
   assign level_a = sync2[(state == ST_LOAD) ? a_now : sel_a];
   assign level_b = sync2[(state == ST_LOAD) ? b_now : sel_b];

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk      (clk),
      .rst      (rst),
      .load     (state == ST_LOAD),
      .count_en (state == ST_COUNT),
      .level    (level_a),
      .count    (cnt_a),
      .sat      (sat_a)
   );

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk      (clk),
      .rst      (rst),
      .load     (state == ST_LOAD),
      .count_en (state == ST_COUNT),
      .level    (level_b),
      .count    (cnt_b),
      .sat      (sat_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         lfsr      <= ZERO_SEED_SUB;
         win_q     <= '0;
         win_cnt   <= '0;
         vote_en_q <= 1'b0;
         bit_idx   <= '0;
         vote_idx  <= '0;
         ones      <= '0;
         resp_sh   <= '0;
         sat_sh    <= 1'b0;
         sel_a     <= '0;
         sel_b     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         response  <= '0;
         sat       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: if (start) begin
               lfsr      <= (challenge == 8'h00) ? ZERO_SEED_SUB : challenge;
               win_q     <= (window == '0) ? WIN_W'(1) : window;
               vote_en_q <= vote_en;
               bit_idx   <= '0;
               vote_idx  <= '0;
               ones      <= '0;
               resp_sh   <= '0;
               sat_sh    <= 1'b0;
               busy      <= 1'b1;
               state     <= ST_LOAD;
            end
            ST_LOAD: begin
               sel_a   <= a_now;
               sel_b   <= b_now;
               win_cnt <= win_q;
               state   <= ST_COUNT;
            end
            ST_COUNT: begin
               if (win_cnt == WIN_W'(1))
                  state <= ST_CMP;
               else
                  win_cnt <= win_cnt - 1'b1;
            end
            ST_CMP: begin
               sat_sh <= sat_sh | sat_a | sat_b;
               if (!last_vote) begin
                  vote_idx <= vote_idx + 3'd1;
                  ones     <= ones_next;
                  state    <= ST_LOAD;
               end else begin
                  vote_idx <= '0;
                  ones     <= '0;
                  resp_sh  <= resp_next;
                  lfsr     <= lfsr_step(lfsr);
                  if (last_bit) begin
                     response <= resp_next;
                     sat      <= sat_sh | sat_a | sat_b;
                     done     <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     state   <= ST_LOAD;
                  end
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ro_puf_eval.sv
// Self-checking bench for ro_puf_eval: recorded oscillator waveforms feed a
// behavioural model of window counting, pair selection and voting.
module tb_ro_puf_eval;

   localparam int NUM_RO    = 16;
   localparam int WIN_W     = 16;
   localparam int RESP_BITS = 8;
   localparam int VOTES     = 3;
   localparam int HIST_N    = 65536;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [7:0]           challenge;
   logic [WIN_W-1:0]     window;
   logic                 vote_en;
   logic [NUM_RO-1:0]    ro_in;
   logic                 busy, done, sat;
   logic [RESP_BITS-1:0] response;
   logic                 busy_s, done_s, sat_s;
   logic [RESP_BITS-1:0] response_s;

   ro_puf_eval #(.NUM_RO(NUM_RO), .CNT_W(12), .WIN_W(WIN_W), .RESP_BITS(RESP_BITS), .VOTES(VOTES)) dut (
      .clk(clk), .rst(rst), .start(start), .challenge(challenge), .window(window),
      .vote_en(vote_en), .ro_in(ro_in), .busy(busy), .done(done), .response(response), .sat(sat)
   );

   ro_puf_eval #(.NUM_RO(NUM_RO), .CNT_W(4), .WIN_W(WIN_W), .RESP_BITS(RESP_BITS), .VOTES(VOTES)) dut_s (
      .clk(clk), .rst(rst), .start(start), .challenge(challenge), .window(window),
      .vote_en(vote_en), .ro_in(ro_in), .busy(busy_s), .done(done_s), .response(response_s), .sat(sat_s)
   );

   always #5 clk = ~clk;

   int                cyc = 0;
   int                base = 0;
   int                phase [NUM_RO];
   bit                jitter = 1'b0;
   bit                all_zero = 1'b0;
   logic [NUM_RO-1:0] hist [HIST_N];
   int                n_cmp = 0;
   int                n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Oscillator i toggles every i+2 clocks relative to the run base, with optional hold-jitter.
   initial begin
      logic [NUM_RO-1:0] nxt;
      for (int i = 0; i < NUM_RO; i++) phase[i] = 0;
      ro_in   = '0;
      hist[0] = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         for (int i = 0; i < NUM_RO; i++) begin
            nxt[i] = 1'(((cyc - base + phase[i]) / (i + 2)) % 2);
            if (all_zero)
               nxt[i] = 1'b0;
            else if (jitter && $urandom_range(0, 11) == 0)
               nxt[i] = ro_in[i];
         end
         ro_in = nxt;
         if (cyc >= HIST_N) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, HIST_N);
            $fatal(1, "cycle budget exceeded");
         end
         hist[cyc] = nxt;
      end
   end

   // Rising edges of channel ch seen by a window whose LOAD cycle is L (2-cycle sync delay).
   function automatic int edges(input int ch, input int L, input int w);
      int c = 0;
      for (int n = L - 1; n <= L + w - 2; n++)
         if (hist[n][ch] && !hist[n-1][ch]) c++;
      return c;
   endfunction

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model(input int s, input logic [7:0] seed, input int w, input int v,
                        output logic [7:0] r12, output bit s12, output logic [7:0] r4, output bit s4);
      logic [7:0] l;
      int a, b, ca, cb, o12, o4, m, load_cyc;
      l = (seed == 8'h00) ? 8'h01 : seed;
      m = 0; r12 = '0; r4 = '0; s12 = 0; s4 = 0;
      for (int bit_n = 0; bit_n < RESP_BITS; bit_n++) begin
         a = int'(l) % 16;
         b = int'(l) / 16;
         if (b == a) b = a ^ 1;
         o12 = 0; o4 = 0;
         for (int t = 0; t < v; t++) begin
            load_cyc = s + 1 + m * (w + 2);
            m++;
            ca = edges(a, load_cyc, w);
            cb = edges(b, load_cyc, w);
            if (ca >= 4095 || cb >= 4095) s12 = 1;
            if (ca >= 15 || cb >= 15) s4 = 1;
            if (min_i(ca, 4095) > min_i(cb, 4095)) o12++;
            if (min_i(ca, 15) > min_i(cb, 15)) o4++;
         end
         r12[bit_n] = (o12 > v / 2);
         r4[bit_n]  = (o4 > v / 2);
         l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
   endtask

   task automatic set_phases(input bit rnd);
      for (int i = 0; i < NUM_RO; i++)
         phase[i] = rnd ? int'($urandom_range(0, 2 * (i + 2) - 1)) : 0;
   endtask

   task automatic run(input string name, input logic [7:0] seed, input int w, input bit ve, input bit poke);
      int s, eff_w, v, n_exp, extra;
      bit seen;
      logic [7:0] r12, r4;
      bit s12, s4;
      @(negedge clk);
      base = cyc;
      repeat (4) @(negedge clk);
      s = cyc;
      start = 1'b1; challenge = seed; window = w[WIN_W-1:0]; vote_en = ve;
      check({name, "_busy_before"}, 32'(busy), 32'd0);
      @(negedge clk);
      start = 1'b0; challenge = 8'($urandom); window = WIN_W'($urandom); vote_en = 1'($urandom);
      check({name, "_busy_after"}, 32'(busy), 32'd1);
      eff_w = (w == 0) ? 1 : w;
      v     = ve ? VOTES : 1;
      n_exp = RESP_BITS * v * (eff_w + 2);
      seen  = 0;
      for (int i = 0; i < n_exp + 50; i++) begin
         if (done) begin
            seen = 1;
            break;
         end
         start = (poke && i == 10);
         @(negedge clk);
      end
      start = 1'b0;
      check({name, "_done_seen"}, 32'(seen), 32'd1);
      check({name, "_latency"}, 32'(cyc - s), 32'(n_exp + 1));
      check({name, "_done_s"}, 32'(done_s), 32'd1);
      check({name, "_busy_in_done"}, 32'(busy), 32'd1);
      model(s, seed, eff_w, v, r12, s12, r4, s4);
      check({name, "_response"}, 32'(response), 32'(r12));
      check({name, "_sat"}, 32'(sat), 32'(s12));
      check({name, "_response_c4"}, 32'(response_s), 32'(r4));
      check({name, "_sat_c4"}, 32'(sat_s), 32'(s4));
      @(negedge clk);
      check({name, "_done_pulse"}, 32'(done), 32'd0);
      check({name, "_busy_drop"}, 32'(busy), 32'd0);
      if (poke) begin
         extra = 0;
         repeat (n_exp + 20) begin
            @(negedge clk);
            if (done) extra++;
         end
         check({name, "_no_second_done"}, 32'(extra), 32'd0);
      end
   endtask

   initial begin
      int s;
      rst = 1'b1; start = 1'b0; challenge = '0; window = '0; vote_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_response", 32'(response), 32'd0);
      check("rst_sat", 32'(sat), 32'd0);
      rst = 1'b0;

      set_phases(0);
      run("t1_seed5a", 8'h5A, 100, 1'b0, 1'b0);

      set_phases(1);
      run("t2_seed00", 8'h00, 40, 1'b0, 1'b0);
      run("t2_seed01", 8'h01, 40, 1'b0, 1'b0);

      all_zero = 1'b1;
      run("t3_zero", 8'hFF, 30, 1'b0, 1'b0);
      check("t3_resp_zero", 32'(response), 32'd0);
      all_zero = 1'b0;

      set_phases(0);
      run("t4_sat", 8'h10, 200, 1'b0, 1'b0);

      set_phases(1);
      jitter = 1'b1;
      run("t5_vote", 8'($urandom), 50, 1'b1, 1'b0);
      run("t_win0", 8'($urandom), 0, 1'b1, 1'b0);
      jitter = 1'b0;

      // Abort mid-COUNT of bit 3 with an asynchronous reset.
      @(negedge clk);
      base = cyc;
      repeat (4) @(negedge clk);
      s = cyc;
      start = 1'b1; challenge = 8'h3C; window = 16'd20; vote_en = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (cyc < s + 1 + 3 * 22 + 5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_response", 32'(response), 32'd0);
      check("t6_rst_done", 32'(done), 32'd0);
      check("t6_rst_response_c4", 32'(response_s), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_idle_busy", 32'(busy), 32'd0);
      run("t6_poke", 8'hC3, 25, 1'b0, 1'b1);

      for (int r = 0; r < 5; r++) begin
         set_phases(1);
         jitter = 1'($urandom);
         run($sformatf("rnd%0d", r), 8'($urandom), int'($urandom_range(0, 30)), 1'($urandom), 1'b0);
      end
      jitter = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ro_puf_eval.md
# ro_puf_eval

Parametrised ring-oscillator PUF evaluation engine for the ctpuf design. It takes a challenge seed, derives a sequence of oscillator-pair selections from it, and counts rising edges of both selected oscillators over a programmable window. It compares the two counts to produce one response bit per pair and can optionally majority-vote each bit over repeated measurements. It sits between the oscillator array (external, asynchronous `ro_in`) and the top-level IO wrapper.

## Interface

Parameters:
- `NUM_RO`, 16: number of oscillator inputs. Legal values are 4, 8 or 16. `SEL_W = log2(NUM_RO)`.
- `CNT_W`, 12: edge-counter width. Counters saturate.
- `WIN_W`, 16: measurement-window register width.
- `RESP_BITS`, 8: response bits per evaluation.
- `VOTES`, 3: repeats per bit when voting is enabled. Must be odd, 1..7.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin an evaluation. Sampled only in IDLE.
- `challenge` in 8: LFSR seed, captured on the accepted `start`.
- `window` in WIN_W: count cycles per measurement, captured on the accepted `start`. A value of 0 is treated as 1.
- `vote_en` in 1: 1 means `VOTES` repeats per bit, 0 means one measurement per bit. Captured on the accepted `start`.
- `ro_in` in NUM_RO: asynchronous oscillator signals.
- `busy` out 1: high from the cycle after `start` is accepted until DONE is exited.
- `done` out 1: one-cycle pulse in the DONE state.
- `response` out RESP_BITS: last completed response. Held until the next DONE or reset.
- `sat` out 1: high if any counter saturated during the last evaluation. Updated at DONE.

## Operation

- Every `ro_in` bit passes through a 2-flop synchroniser. The two selected channels are muxed, rising-edge detected and counted.
- The LFSR is 8 bits, Fibonacci, polynomial x^8+x^6+x^5+x^4+1. A seed of 0x00 is replaced by 0x01.
- Pair selection from the current LFSR state:
  - A = `lfsr[SEL_W-1:0]`.
  - B = `lfsr[2*SEL_W-1:SEL_W]`.
  - If B == A, then B = A ^ 1.
- State machine:
  - IDLE: on `start`, capture the inputs, clear the bit and vote indices, go to LOAD.
  - LOAD (1 cycle): clear both counters and the per-bit saturation, latch the A/B selections, and preload each edge detector's previous value with the current synchronised level, so a mux change creates no false edge. Go to COUNT.
  - COUNT (W cycles, W = max(window,1)): increment a counter on each detected rising edge, saturating at 2^CNT_W-1 and setting the sticky saturation flag. Go to CMP.
  - CMP (1 cycle):
    - vote_bit = (cntA > cntB). A tie gives 0.
    - Accumulate the ones count.
    - If more votes remain, go back to LOAD with the same pair.
    - Otherwise: response bit[idx] = (ones > V/2), step the LFSR once, then go to LOAD for the next bit, or to DONE if the last bit was just resolved.
  - DONE (1 cycle): `done`=1; `response` and `sat` are updated from the shadow registers. Go to IDLE.
- Bit order: bit 0 is resolved first, from the seed state before any LFSR step.
- `start` while `busy` is ignored, with no queueing.
- Reset values: `busy`=0, `done`=0, `response`=0, `sat`=0, state IDLE, LFSR=0x01, counters 0. A reset in any state aborts immediately and leaves no partial response.

## Timing

- V = `vote_en` ? VOTES : 1.
- `start` is sampled high in IDLE at edge k. `busy` is high from k+1.
- `done` is high in the cycle beginning at edge k + RESP_BITS·V·(W+2) + 1. `busy` drops the same cycle `done` falls.
- `response` and `sat` change only on the edge entering DONE and are stable while `done`=1.
- Synchroniser latency is 2 cycles. Edges arriving in the 2 cycles before LOAD can appear in the window. This is accepted, and benches align to it.
- Detectable `ro_in` toggle rate is below clk/4. Faster rates alias, which is acceptable for a PUF.

## Structure

- `puf_pkg`: state enum, LFSR taps constant, zero-seed substitute 0x01, and a `SEL_W` function.
- Sub-module `ro_edge_counter`: previous-value register with preload, rising-edge detect, saturating CNT_W counter, and sticky saturation flag. Instantiated twice, once for A and once for B.
- The synchronisers, mux, LFSR, vote accumulator and FSM live in `ro_puf_eval`.

## Test plan

Common setup: `NUM_RO`=16; `ro_in[i]` toggles every i+2 clocks.

1. seed 0x5A, window 100, `vote_en`=0 -> `done` exactly 8·102+1 = 817 cycles after `start`; `response` matches a model of the LFSR and counts; `sat`=0.
2. seed 0x00 vs seed 0x01, otherwise identical -> identical responses.
3. All `ro_in` held at 0, seed 0xFF -> every tie gives `response`=0x00, `sat`=0, latency unchanged.
4. `CNT_W`=4, window 200 -> `sat`=1 at DONE; counts stick at 15 (A=B=15 gives a 0 bit).
5. `vote_en`=1, `VOTES`=3, window 50 -> `done` at 8·3·52+1 = 1249 cycles; a channel jittered in 1 of 3 votes does not flip its bit.
6. `rst` pulsed mid-COUNT of bit 3 -> `busy`=0 and `response`=0 immediately; a `start` pulse during `busy` produces no second `done`.
